// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - instruction byte prefetch queue feeding the opcode decoder
module prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect,
  input  logic [15:0]              redirect_pc,
  output logic                     mem_rd,
  output logic [15:0]              mem_addr,
  input  logic                     mem_gnt,
  input  logic [7:0]               mem_rdata,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [7:0]               q_byte0,
  output logic [7:0]               q_byte1,
  output logic [7:0]               q_byte2,
  output logic [15:0]              q_pc,
  input  logic [1:0]               pop,
  output logic                     pop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_CMP = (CW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [CW-1:0] r_count;
  logic [15:0]   r_q_pc;
  logic [15:0]   r_fetch_pc;
  logic          r_inflight;
  logic          r_tag;
  logic          r_epoch;
  logic          r_pop_err;

  logic [CW:0]   w_occ;
  logic          w_accept;
  logic          w_push;
  logic [CW-1:0] w_pop_ext;
  logic          w_pop_bad;
  logic [CW-1:0] w_pop_eff;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_idx1;
  logic [AW-1:0] w_idx2;

  // Occupancy counts the outstanding read so a return always finds a free slot.
  assign w_occ     = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign mem_rd    = rst_n & ~redirect & (w_occ < DEPTH_CMP);
  assign mem_addr  = r_fetch_pc;
  assign w_accept  = mem_rd & mem_gnt;
  assign w_push    = r_inflight & (r_tag == r_epoch);

  assign w_pop_ext = CW'(pop);
  assign w_pop_bad = w_pop_ext > r_count;
  assign w_pop_eff = w_pop_bad ? r_count : w_pop_ext;

  // head + count is the slot just past the pre-pop tail, i.e. new_head + (count - pop).
  assign w_wr_idx  = r_head + r_count[AW-1:0];
  assign w_idx1    = r_head + AW'(1);
  assign w_idx2    = r_head + AW'(2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_head     <= '0;
      r_count    <= '0;
      r_q_pc     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_tag      <= 1'b0;
      r_epoch    <= 1'b0;
      r_pop_err  <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 16'd1;
        r_tag      <= r_epoch;
      end
      // A redirect cannot coincide with an accept since mem_rd is held low.
      if (redirect) begin
        r_count    <= '0;
        r_q_pc     <= redirect_pc;
        r_fetch_pc <= redirect_pc;
        r_epoch    <= ~r_epoch;
      end else begin
        if (w_pop_bad) begin
          r_pop_err <= 1'b1;
        end
        r_head  <= r_head + w_pop_eff[AW-1:0];
        r_q_pc  <= r_q_pc + 16'(w_pop_eff);
        r_count <= r_count - w_pop_eff + CW'(w_push);
        if (w_push) begin
          r_mem[w_wr_idx] <= mem_rdata;
        end
      end
    end
  end

  assign q_count = r_count;
  assign q_pc    = r_q_pc;
  assign pop_err = r_pop_err;
  assign q_byte0 = (r_count > CW'(0)) ? r_mem[r_head] : 8'h00;
  assign q_byte1 = (r_count > CW'(1)) ? r_mem[w_idx1] : 8'h00;
  assign q_byte2 = (r_count > CW'(2)) ? r_mem[w_idx2] : 8'h00;

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - directed self-checking bench for prefetch_queue
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_rdata;
  logic [2:0]  q_count;
  logic [7:0]  q_byte0;
  logic [7:0]  q_byte1;
  logic [7:0]  q_byte2;
  logic [15:0] q_pc;
  logic [1:0]  pop;
  logic        pop_err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_pc;
  logic [15:0] exp_fetch;
  logic [15:0] a;
  logic        g;

  always #5 clk = ~clk;

  prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0200)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rdata  (mem_rdata),
    .q_count    (q_count),
    .q_byte0    (q_byte0),
    .q_byte1    (q_byte1),
    .q_byte2    (q_byte2),
    .q_pc       (q_pc),
    .pop        (pop),
    .pop_err    (pop_err)
  );

  // Memory returns the low address byte one cycle after acceptance; 8'hEE otherwise.
  always @(posedge clk) begin
    mem_rdata <= (mem_rd && mem_gnt) ? mem_addr[7:0] : 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; mem_gnt = 1'b1; pop = 2'd0;
    cyc(); cyc();
    check("rst_count", 32'(q_count), 32'd0);
    check("rst_pc", 32'(q_pc), 32'h0200);
    check("rst_rd", 32'(mem_rd), 32'd0);
    check("rst_err", 32'(pop_err), 32'd0);
    check("rst_b0", 32'(q_byte0), 32'h00);

    // Fill from RESET_PC
    rst_n = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      a = 16'h0200 + 16'(i);
      check("t1_rd", 32'(mem_rd), 32'd1);
      check("t1_addr", 32'(mem_addr), 32'(a));
      cyc();
    end
    check("t1_stop", 32'(mem_rd), 32'd0);
    cyc();
    check("t1_count", 32'(q_count), 32'd4);
    check("t1_b0", 32'(q_byte0), 32'h00);
    check("t1_b1", 32'(q_byte1), 32'h01);
    check("t1_b2", 32'(q_byte2), 32'h02);
    check("t1_pc", 32'(q_pc), 32'h0200);
    check("t1_rd_full", 32'(mem_rd), 32'd0);

    // Redirect while the 0204 read is returning
    pop = 2'd1; cyc();
    check("t3_count", 32'(q_count), 32'd3);
    check("t3_pc", 32'(q_pc), 32'h0201);
    check("t3_addr", 32'(mem_addr), 32'h0204);
    pop = 2'd0; cyc();
    redirect = 1'b1; redirect_pc = 16'h8000; #1;
    check("t3_rd_redir", 32'(mem_rd), 32'd0);
    cyc();
    redirect = 1'b0; #1;
    check("t3_count0", 32'(q_count), 32'd0);
    check("t3_qpc", 32'(q_pc), 32'h8000);
    check("t3_rd", 32'(mem_rd), 32'd1);
    check("t3_addr8000", 32'(mem_addr), 32'h8000);
    cyc();
    check("t3_nodrop_stale", 32'(q_count), 32'd0);
    cyc();
    check("t3_count1", 32'(q_count), 32'd1);
    check("t3_b0", 32'(q_byte0), 32'h00);
    check("t3_b1_mask", 32'(q_byte1), 32'h00);
    cyc();
    check("t3_b1", 32'(q_byte1), 32'h01);
    cyc(); cyc();
    check("t3_full", 32'(q_count), 32'd4);
    check("t3_b2", 32'(q_byte2), 32'h02);
    check("t3_pc_hold", 32'(q_pc), 32'h8000);

    // Steady stream, one pop per cycle
    pop = 2'd1; exp_pc = 16'h8000;
    for (int i = 0; i < 256; i++) begin
      cyc();
      exp_pc = exp_pc + 16'd1;
      check("t2_pc", 32'(q_pc), 32'(exp_pc));
      check("t2_b0", 32'(q_byte0), 32'(exp_pc[7:0]));
      check("t2_count_range", 32'(q_count >= 3'd2 && q_count <= 3'd4), 32'd1);
    end
    check("t2_err", 32'(pop_err), 32'd0);
    pop = 2'd0;

    // Toggling grant, pop 2 when possible
    redirect = 1'b1; redirect_pc = 16'h1234;
    cyc();
    redirect = 1'b0; #1;
    exp_pc = 16'h1234; exp_fetch = 16'h1234; g = 1'b1;
    for (int i = 0; i < 40; i++) begin
      check("t4_pc", 32'(q_pc), 32'(exp_pc));
      if (q_count >= 3'd1) check("t4_b0", 32'(q_byte0), 32'(exp_pc[7:0]));
      if (q_count >= 3'd2) check("t4_b1", 32'(q_byte1), 32'(8'(exp_pc[7:0] + 8'd1)));
      if (mem_rd) check("t4_addr", 32'(mem_addr), 32'(exp_fetch));
      mem_gnt = g;
      pop = (q_count >= 3'd2) ? 2'd2 : 2'd0;
      if (pop == 2'd2) exp_pc = exp_pc + 16'd2;
      if (mem_rd && mem_gnt) exp_fetch = exp_fetch + 16'd1;
      g = ~g;
      cyc();
    end
    pop = 2'd0; mem_gnt = 1'b1;

    // Wrap through FFFF
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    cyc();
    redirect = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      a = 16'hFFFE + 16'(i);
      check("t5_rd", 32'(mem_rd), 32'd1);
      check("t5_addr", 32'(mem_addr), 32'(a));
      cyc();
    end
    check("t5_stop", 32'(mem_rd), 32'd0);
    cyc();
    check("t5_count", 32'(q_count), 32'd4);
    check("t5_b0", 32'(q_byte0), 32'hFE);
    check("t5_b1", 32'(q_byte1), 32'hFF);
    check("t5_b2", 32'(q_byte2), 32'h00);
    check("t5_pc", 32'(q_pc), 32'hFFFE);
    pop = 2'd3; cyc();
    check("t5_pc_pop3", 32'(q_pc), 32'h0001);
    check("t5_count1", 32'(q_count), 32'd1);
    check("t5_b0_after", 32'(q_byte0), 32'h01);
    check("t5_err", 32'(pop_err), 32'd0);

    // Illegal pop with one byte queued
    cyc();
    check("t6_err", 32'(pop_err), 32'd1);
    check("t6_count", 32'(q_count), 32'd0);
    check("t6_pc", 32'(q_pc), 32'h0002);
    pop = 2'd0; cyc();
    check("t6_count1", 32'(q_count), 32'd1);
    check("t6_b0", 32'(q_byte0), 32'h02);
    check("t6_err_sticky", 32'(pop_err), 32'd1);
    pop = 2'd3; cyc();
    check("t6_ret_count", 32'(q_count), 32'd1);
    check("t6_ret_pc", 32'(q_pc), 32'h0003);
    check("t6_ret_b0", 32'(q_byte0), 32'h03);
    pop = 2'd0;

    // Back-to-back redirects: last wins
    redirect = 1'b1; redirect_pc = 16'h4444;
    cyc();
    redirect_pc = 16'h5010;
    cyc();
    redirect = 1'b0; #1;
    check("rr_pc", 32'(q_pc), 32'h5010);
    check("rr_count", 32'(q_count), 32'd0);
    check("rr_addr", 32'(mem_addr), 32'h5010);
    cyc(); cyc();
    check("rr_count1", 32'(q_count), 32'd1);
    check("rr_b0", 32'(q_byte0), 32'h10);
    check("rr_err", 32'(pop_err), 32'd1);

    // Asynchronous reset with a return pending
    rst_n = 1'b0; #1;
    check("ar_rd", 32'(mem_rd), 32'd0);
    check("ar_count", 32'(q_count), 32'd0);
    check("ar_pc", 32'(q_pc), 32'h0200);
    check("ar_err", 32'(pop_err), 32'd0);
    cyc();
    check("ar_discard", 32'(q_count), 32'd0);
    rst_n = 1'b1; #1;
    check("ar_addr", 32'(mem_addr), 32'h0200);
    cyc(); cyc();
    check("ar_count1", 32'(q_count), 32'd1);
    check("ar_b0", 32'(q_byte0), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
